// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serial-chain blocks: shifter FSM encodings and
// a constant clog2 used to size the bit and slot counters.
package bit_serializer_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    function automatic int ser_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_serializer_tick_gen.sv
// Bit-slot pulse generator: tick is high on the last cycle of every DIV-cycle
// slot. Cleared synchronously on each word load so the slot grid restarts.
module bit_tick_gen
    import bit_serializer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    generate
        if (DIV == 1) begin : g_div1
            logic unused_div1;
            assign unused_div1 = ^{clk, rst, clear, en};
            assign tick = 1'b1;
        end else begin : g_divn
            localparam int DW = ser_clog2(DIV);
            logic [DW-1:0] div_cnt;

            assign tick = (div_cnt == DW'(DIV - 1));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    div_cnt <= '0;
                end else if (clear) begin
                    div_cnt <= '0;
                end else if (en) begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage with a hold register in front of the shifter so
// back-to-back words stream without gap slots.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int DIV       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             valid_out,
    output logic             sof,
    output logic             busy
);

    localparam int CW = ser_clog2(WIDTH);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] hold_q, shreg_q, load_word;
    logic             hold_full_q, hold_full_nxt;
    logic [CW-1:0]    bit_cnt_q;
    logic             tick, last_slot, accept, load_direct, load_hold, load, emit;

    assign in_ready    = !hold_full_q;
    assign accept      = in_valid && in_ready;
    assign last_slot   = (state == SER_SHIFT) && tick && (bit_cnt_q == CW'(WIDTH - 1));
    assign load_hold   = last_slot && hold_full_q;
    // An accept can only coincide with last_slot when the hold register is empty.
    assign load_direct = accept && ((state == SER_IDLE) || last_slot);
    assign load        = load_hold || load_direct;
    assign load_word   = load_hold ? hold_q : in_data;
    assign emit        = (state == SER_SHIFT) && tick && !last_slot;

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (load),
        .en    (state == SER_SHIFT),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SER_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        hold_full_nxt = hold_full_q;
        case (state)
            SER_IDLE:  if (load) state_nxt = SER_SHIFT;
            SER_SHIFT: if (last_slot && !load) state_nxt = SER_IDLE;
            default:   state_nxt = SER_IDLE;
        endcase
        if (load_hold)                    hold_full_nxt = 1'b0;
        else if (accept && !load_direct)  hold_full_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            data_out    <= 1'b0;
            valid_out   <= 1'b0;
            sof         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hold_full_q <= hold_full_nxt;
            busy        <= (state_nxt == SER_SHIFT) || hold_full_nxt;
            valid_out   <= load || emit;
            sof         <= load;
            if (accept && !load_direct) hold_q <= in_data;

            // shreg_q keeps only the bits not yet emitted; data_out carries the current one.
            if (load) begin
                bit_cnt_q <= '0;
                if (MSB_FIRST) begin
                    data_out <= load_word[WIDTH-1];
                    shreg_q  <= {load_word[WIDTH-2:0], 1'b0};
                end else begin
                    data_out <= load_word[0];
                    shreg_q  <= {1'b0, load_word[WIDTH-1:1]};
                end
            end else if (emit) begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
                if (MSB_FIRST) begin
                    data_out <= shreg_q[WIDTH-1];
                    shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    data_out <= shreg_q[0];
                    shreg_q  <= {1'b0, shreg_q[WIDTH-1:1]};
                end
            end else begin
                data_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: four parameterisations share clk and rst.
module tb_bit_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // a: W5 MSB DIV1, b: W8 MSB DIV1, c: W8 MSB DIV3, d: W8 LSB DIV1
    logic [4:0] in_data_a;
    logic [7:0] in_data_b, in_data_c, in_data_d;
    logic in_valid_a, in_valid_b, in_valid_c, in_valid_d;
    logic in_ready_a, in_ready_b, in_ready_c, in_ready_d;
    logic data_out_a, data_out_b, data_out_c, data_out_d;
    logic valid_out_a, valid_out_b, valid_out_c, valid_out_d;
    logic sof_a, sof_b, sof_c, sof_d;
    logic busy_a, busy_b, busy_c, busy_d;

    bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .DIV(1)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .data_out(data_out_a), .valid_out(valid_out_a), .sof(sof_a), .busy(busy_a));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .DIV(1)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .data_out(data_out_b), .valid_out(valid_out_b), .sof(sof_b), .busy(busy_b));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .DIV(3)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .data_out(data_out_c), .valid_out(valid_out_c), .sof(sof_c), .busy(busy_c));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .DIV(1)) u_d (
        .clk(clk), .rst(rst), .in_data(in_data_d), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .data_out(data_out_d), .valid_out(valid_out_d), .sof(sof_d), .busy(busy_d));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  p5;
        logic [7:0]  w8;
        logic [15:0] w16;
        logic [23:0] stream;
        logic [7:0]  words [3];
        int idx, vcnt, first_c, last_c;
        logic acc;

        in_valid_a = 0; in_valid_b = 0; in_valid_c = 0; in_valid_d = 0;
        in_data_a = '0; in_data_b = '0; in_data_c = '0; in_data_d = '0;

        // Reset state (rst held low)
        #12;
        chk("rst_in_ready", in_ready_b, 1);
        chk("rst_busy",     busy_b,     0);
        chk("rst_valid",    valid_out_b, 0);
        chk("rst_data",     data_out_b, 0);
        chk("rst_sof",      sof_b,      0);
        rst = 1'b1;
        step();

        // 1: 10110 on W5, bits A+1..A+5
        p5 = 5'b10110;
        in_valid_a = 1; in_data_a = p5;
        step();
        in_valid_a = 0; in_data_a = 5'b00000;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("t1_vd_c%0d", c), {valid_out_a, data_out_a},
                (c <= 5) ? {1'b1, p5[5-c]} : 2'b00);
            chk($sformatf("t1_sof_c%0d", c), sof_a, (c == 1) ? 1 : 0);
            step();
        end
        chk("t1_idle_busy", busy_a, 0);

        // 2: A5,3C,FF streamed with in_valid held high
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        idx = 0; vcnt = 0; first_c = 0; last_c = 0; stream = '0;
        in_valid_b = 1; in_data_b = words[0];
        for (int c = 1; c <= 28; c++) begin
            acc = in_valid_b & in_ready_b;
            step();
            if (acc) begin
                idx++;
                if (idx < 3) in_data_b = words[idx];
                else begin in_valid_b = 0; in_data_b = 8'h00; end
            end
            if (valid_out_b) begin
                stream = {stream[22:0], data_out_b};
                vcnt++;
                if (first_c == 0) first_c = c;
                last_c = c;
            end
            if (c == 2) chk("t2_ready_low_hold_full", in_ready_b, 0);
            if (c == 1 || c == 2 || c == 9 || c == 17)
                chk($sformatf("t2_sof_c%0d", c), sof_b, (c != 2) ? 1 : 0);
        end
        chk("t2_stream",  stream, 24'hA53CFF);
        chk("t2_vcount",  vcnt, 24);
        chk("t2_first",   first_c, 1);
        chk("t2_nogap",   last_c, 24);
        chk("t2_idle",    busy_b, 0);

        // 3: 0x81 with DIV=3, pulses at A+1, A+4, ..., A+22
        w8 = 8'h81;
        in_valid_c = 1; in_data_c = w8;
        step();
        in_valid_c = 0; in_data_c = 8'h00;
        for (int c = 1; c <= 25; c++) begin
            if (((c - 1) % 3 == 0) && c <= 22)
                chk($sformatf("t3_vd_c%0d", c), {valid_out_c, data_out_c}, {1'b1, w8[7-(c-1)/3]});
            else
                chk($sformatf("t3_vd_c%0d", c), {valid_out_c, data_out_c}, 2'b00);
            step();
        end

        // 4: LSB-first 0x01
        w8 = 8'h01;
        in_valid_d = 1; in_data_d = w8;
        step();
        in_valid_d = 0; in_data_d = 8'h00;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("t4_vd_c%0d", c), {valid_out_d, data_out_d},
                (c <= 8) ? {1'b1, w8[c-1]} : 2'b00);
            step();
        end

        // 6: new accept on the last bit slot of 0x96, hold empty
        w16 = 16'h965A;
        in_valid_b = 1; in_data_b = 8'h96;
        step();
        in_valid_b = 0; in_data_b = 8'h00;
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("t6_vd_c%0d", c), {valid_out_b, data_out_b},
                (c <= 16) ? {1'b1, w16[16-c]} : 2'b00);
            if (c == 9) begin
                chk("t6_sof_c9", sof_b, 1);
                chk("t6_busy_c9", busy_b, 1);
                chk("t6_ready_c9", in_ready_b, 1);
            end
            if (c == 8) begin in_valid_b = 1; in_data_b = 8'h5A; end
            step();
            if (c == 8) begin in_valid_b = 0; in_data_b = 8'h00; end
        end

        // 5: async reset at bit 3 of 0xF0 with 0x0F held
        in_valid_b = 1; in_data_b = 8'hF0;
        step();
        in_data_b = 8'h0F;
        step();
        in_valid_b = 0; in_data_b = 8'h00;
        chk("t5_hold_full", in_ready_b, 0);
        step();
        step();
        chk("t5_bit3", {valid_out_b, data_out_b}, 2'b11);
        rst = 1'b0;
        #1;
        chk("t5_rst_valid", valid_out_b, 0);
        chk("t5_rst_data",  data_out_b, 0);
        chk("t5_rst_sof",   sof_b, 0);
        chk("t5_rst_busy",  busy_b, 0);
        chk("t5_rst_ready", in_ready_b, 1);
        #2;
        rst = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (valid_out_b) vcnt++;
        end
        chk("t5_no_emit_after_rst", vcnt, 0);
        chk("t5_busy_after", busy_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
